// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: Mealy match output, registered copy,
// saturating match counter, and overlap / non-overlap detection modes.
module seq_detect_param #(
    parameter int unsigned          PAT_W   = 4,
    parameter logic [PAT_W-1:0]     PATTERN = PAT_W'(4'b1011),
    parameter int unsigned          CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      en,
    input  logic                      a,
    input  logic                      overlap,
    input  logic                      clr_cnt,
    output logic                      y,
    output logic                      y_reg,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [$clog2(PAT_W)-1:0]  state
);

    localparam int unsigned SW = $clog2(PAT_W);
    localparam int unsigned NS = 1 << SW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int unsigned i);
        logic [PAT_W-1:0] t;
        t = PATTERN >> (PAT_W - 1 - i);
        return t[0];
    endfunction

    // Longest proper prefix of PATTERN that is a suffix of (prefix of length s, then b).
    // For the completing bit this is the pattern's own border, i.e. the overlap fallback.
    function automatic int unsigned next_len(input int unsigned s, input logic b);
        int unsigned best;
        logic        ok;
        logic        c;
        best = 0;
        if (s < PAT_W) begin
            for (int unsigned k = 1; k < PAT_W; k++) begin
                if (k <= s + 1) begin
                    ok = 1'b1;
                    for (int unsigned i = 0; i < k; i++) begin
                        c = ((s + 1 - k + i) == s) ? b : pat_bit(s + 1 - k + i);
                        if (c != pat_bit(i)) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
            end
        end
        return best;
    endfunction

    logic [SW-1:0] nxt0 [NS];
    logic [SW-1:0] nxt1 [NS];
    logic [SW-1:0] state_nxt;

    // Elaboration-time transition table indexed by current state, one per input bit value.
    for (genvar g = 0; g < NS; g++) begin : g_tab
        localparam int unsigned N0 = next_len(g, 1'b0);
        localparam int unsigned N1 = next_len(g, 1'b1);
        assign nxt0[g] = SW'(N0);
        assign nxt1[g] = SW'(N1);
    end

    // Mealy match and next-state selection; overlap only matters on the completing bit.
    always_comb begin
        state_nxt = state;
        y         = 1'b0;
        if (res && en) begin
            y = (state == SW'(PAT_W - 1)) && (a == PATTERN[0]);
            if (y && !overlap) state_nxt = '0;
            else               state_nxt = a ? nxt1[state] : nxt0[state];
        end
    end

    // Match-progress state and registered match flag.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= '0;
            y_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            y_reg <= y;
        end
    end

    // Saturating match counter; clear wins over increment.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (y && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances (default, 2-bit counter,
// 5-bit pattern 11011) driven by directed vectors with hand-computed expectations.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       a   = 1'b0;
    logic       ov  = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] en  = 3'b000;

    logic       y0, yr0, y1, yr1, y2, yr2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic [1:0] st0, st1;
    logic [2:0] st2;

    always #5 clk = ~clk;

    seq_detect_param dut0 (
        .clk(clk), .res(res), .en(en[0]), .a(a), .overlap(ov), .clr_cnt(clr),
        .y(y0), .y_reg(yr0), .match_cnt(cnt0), .state(st0)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut1 (
        .clk(clk), .res(res), .en(en[1]), .a(a), .overlap(ov), .clr_cnt(clr),
        .y(y1), .y_reg(yr1), .match_cnt(cnt1), .state(st1)
    );

    seq_detect_param #(.PAT_W(5), .PATTERN(5'b11011), .CNT_W(8)) dut2 (
        .clk(clk), .res(res), .en(en[2]), .a(a), .overlap(ov), .clr_cnt(clr),
        .y(y2), .y_reg(yr2), .match_cnt(cnt2), .state(st2)
    );

    typedef struct {
        int unsigned d;
        logic        ey;
        int unsigned est;
        int unsigned ecnt;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void get_out(input int unsigned d, output logic yo, output logic yro,
                                    output int unsigned so, output int unsigned co);
        case (d)
            0:       begin yo = y0; yro = yr0; so = 32'(st0); co = 32'(cnt0); end
            1:       begin yo = y1; yro = yr1; so = 32'(st1); co = 32'(cnt1); end
            default: begin yo = y2; yro = yr2; so = 32'(st2); co = 32'(cnt2); end
        endcase
    endfunction

    task automatic chk(input string tag, input string what, input int unsigned act, input int unsigned exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    // Monitor: y checked mid-cycle, registered outputs checked just after the edge.
    initial begin
        exp_t        it;
        logic        yo, yro;
        int unsigned so, co;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                it = q[0];
                n_vec++;
                get_out(it.d, yo, yro, so, co);
                chk(it.tag, "y", 32'(yo), 32'(it.ey));
                @(posedge clk);
                #1;
                get_out(it.d, yo, yro, so, co);
                chk(it.tag, "state", so, it.est);
                chk(it.tag, "match_cnt", co, it.ecnt);
                chk(it.tag, "y_reg", 32'(yro), 32'(it.ey));
                it = q.pop_front();
            end
        end
    end

    task automatic step(input int unsigned d, input logic r, input logic e, input logic av,
                        input logic o, input logic c, input logic ey, input int unsigned est,
                        input int unsigned ecnt, input string tag);
        exp_t it;
        @(negedge clk);
        res = r;
        en  = 3'(e) << d;
        a   = av;
        ov  = o;
        clr = c;
        it.d = d; it.ey = ey; it.est = est; it.ecnt = ecnt; it.tag = tag;
        q.push_back(it);
    endtask

    function automatic int unsigned dig(input string s, input int i);
        byte c;
        c = s.getc(i);
        return 32'(c) - 32'd48;
    endfunction

    // Feed a bit stream with per-bit overlap and expected y / state / count digits.
    task automatic run(input int unsigned d, input string tag, input string bits, input string ovs,
                       input string ys, input string sts, input string cnts);
        for (int i = 0; i < bits.len(); i++) begin
            step(d, 1'b1, 1'b1, dig(bits, i) == 1, dig(ovs, i) == 1, 1'b0,
                 dig(ys, i) == 1, dig(sts, i), dig(cnts, i), $sformatf("%s.%0d", tag, i + 1));
        end
    endtask

    task automatic rst(input int unsigned d, input string tag);
        step(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, tag);
    endtask

    initial begin
        int k;
        // Basic overlapping detection with y_reg follow-up and idle hold
        rst(0, "rst0");
        run(0, "A", "101110111011", "111111111111", "000100010001", "123112311231", "000111122223");
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3, "A.idle");

        // Same stream, overlap then non-overlap
        rst(0, "rstB1");
        run(0, "B1", "1011011", "1111111", "0001001", "1231231", "0001112");
        rst(0, "rstB0");
        run(0, "B0", "1011011", "0000000", "0001000", "1230011", "0001111");

        // Mismatch fallbacks (3->2, 2->0) in non-overlap mode
        rst(0, "rstM");
        run(0, "M", "101011100", "000000000", "000001000", "123230120", "000001111");

        // Overlap toggled on non-completing bits has no effect
        rst(0, "rstT");
        run(0, "T", "1011011", "0101010", "0001001", "1231230", "0001112");

        // en=0 holds state while a toggles, then resumes
        rst(0, "rstC");
        run(0, "C", "101", "111", "000", "123", "000");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, "C.hold1");
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0, "C.hold2");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, "C.hold3");
        run(0, "Cr", "1", "1", "1", "1", "1");

        // Reset mid-pattern discards partial match and count
        rst(0, "rstD");
        run(0, "D", "1011101", "1111111", "0001000", "1231123", "0001111");
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "D.res");
        run(0, "Dr", "1", "1", "0", "1", "0");

        // 2-bit counter saturates, then clear on a match cycle
        rst(1, "rstS");
        run(1, "S", "1011011011011011011", "1111111111111111111",
            "0001001001001001001", "1231231231231231231", "0001112223333333333");
        run(1, "Sc", "01", "11", "00", "23", "33");
        step(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, "S.clr");
        run(1, "Sr", "011", "111", "001", "231", "001");

        // 5-bit pattern 11011 with border fallback of 2
        rst(2, "rstP");
        run(2, "P", "110110111010", "111111111111", "000010010000", "123423422340", "000011122222");

        @(negedge clk);
        en  = 3'b000;
        clr = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #5;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
